// File: rtl/tail_light_pkg.sv
// Shared types and defaults for the tail-light control slice.
// Turn stalk FSM state encoding and helper for counter sizing.
package tail_light_pkg;

    localparam int DEB_CYCLES_DEFAULT    = 4;
    localparam int MAX_ON_CYCLES_DEFAULT = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEFT    = 2'd1,
        RIGHT   = 2'd2,
        LOCKOUT = 2'd3
    } turn_state_e;

    // Width for a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one bouncy contact.
// The output only moves after DEB_CYCLES consecutive synchronized samples disagree with it.
module sw_debounce
    import tail_light_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int             CW   = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Any sample matching the current debounced value restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_stalk_ctrl.sv
// Turn-signal stalk controller: debounces the levers and hazard button, runs the
// turn FSM with steering-return and timeout cancel, and registers lt/rt/haz.
module turn_stalk_ctrl
    import tail_light_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEFAULT,
    parameter int MAX_ON_CYCLES = MAX_ON_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic lever_l,
    input  logic lever_r,
    input  logic haz_btn,
    input  logic steer_ret,
    output logic lt,
    output logic rt,
    output logic haz
);

    localparam int            OW      = cnt_width(MAX_ON_CYCLES);
    localparam logic [OW-1:0] ON_LAST = OW'(MAX_ON_CYCLES - 1);

    logic        deb_l;
    logic        deb_r;
    logic        deb_h;
    logic        deb_h_prev;
    logic        haz_state;
    logic        haz_rise;
    logic        steer_s1;
    logic        steer_s2;
    logic        steer_prev;
    logic        steer_rise;
    logic        entering;
    logic [OW-1:0] on_cnt;
    turn_state_e state;
    turn_state_e next_state;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
        .clk (clk),
        .rst (rst),
        .raw (lever_l),
        .deb (deb_l)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk (clk),
        .rst (rst),
        .raw (lever_r),
        .deb (deb_r)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
        .clk (clk),
        .rst (rst),
        .raw (haz_btn),
        .deb (deb_h)
    );

    // Steering return is a clean level, so it is only synchronized and edge-detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            steer_s1   <= 1'b0;
            steer_s2   <= 1'b0;
            steer_prev <= 1'b0;
        end else begin
            steer_s1   <= steer_ret;
            steer_s2   <= steer_s1;
            steer_prev <= steer_s2;
        end
    end

    assign steer_rise = steer_s2 & ~steer_prev;
    assign haz_rise   = deb_h & ~deb_h_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_h_prev <= 1'b0;
            haz_state  <= 1'b0;
        end else begin
            deb_h_prev <= deb_h;
            if (haz_rise) begin
                haz_state <= ~haz_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cancel causes in LEFT/RIGHT are checked in priority order, own lever first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (deb_l && !deb_r) begin
                    next_state = LEFT;
                end else if (deb_r && !deb_l) begin
                    next_state = RIGHT;
                end
            end
            LEFT: begin
                if (!deb_l) begin
                    next_state = IDLE;
                end else if (deb_r) begin
                    next_state = IDLE;
                end else if (steer_rise) begin
                    next_state = LOCKOUT;
                end else if (on_cnt == ON_LAST) begin
                    next_state = LOCKOUT;
                end
            end
            RIGHT: begin
                if (!deb_r) begin
                    next_state = IDLE;
                end else if (deb_l) begin
                    next_state = IDLE;
                end else if (steer_rise) begin
                    next_state = LOCKOUT;
                end else if (on_cnt == ON_LAST) begin
                    next_state = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (!deb_l && !deb_r) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign entering = ((next_state == LEFT) || (next_state == RIGHT)) && (next_state != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            on_cnt <= '0;
        end else if (entering) begin
            on_cnt <= '0;
        end else if (((state == LEFT) || (state == RIGHT)) && (on_cnt != ON_LAST)) begin
            on_cnt <= on_cnt + 1'b1;
        end
    end

    // The FSM keeps running under hazard; only the turn outputs are masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            lt  <= 1'b0;
            rt  <= 1'b0;
            haz <= 1'b0;
        end else begin
            lt  <= (state == LEFT)  && !haz_state;
            rt  <= (state == RIGHT) && !haz_state;
            haz <= haz_state;
        end
    end

endmodule

// File: doc/turn_stalk_ctrl.md
TURN_STALK_CTRL -- requirements
Module: turn_stalk_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required before a debounced switch value changes.
REQ-002 Parameter MAX_ON_CYCLES, default 1000: maximum continuous cycles a turn command stays active before auto-cancel.
REQ-003 clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 lever_l  input  1  raw asynchronous left-turn lever contact, bouncy.
REQ-006 lever_r  input  1  raw asynchronous right-turn lever contact, bouncy.
REQ-007 haz_btn  input  1  raw asynchronous momentary hazard push-button, bouncy.
REQ-008 steer_ret  input  1  asynchronous steering-returned-to-centre indication; level, not debounced.
REQ-009 lt  output  1  registered left-turn command to the tail-light sequencer.
REQ-010 rt  output  1  registered right-turn command to the tail-light sequencer.
REQ-011 haz  output  1  registered hazard command to the tail-light sequencer.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounced value for lever_l, lever_r and haz_btn SHALL change only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any return to the old value SHALL clear the count.
REQ-014 Each rising edge of debounced haz_btn SHALL toggle haz_state; falling edges SHALL have no effect.
REQ-015 The turn FSM SHALL have states IDLE, LEFT, RIGHT, LOCKOUT.
REQ-016 IDLE: deb_l=1 and deb_r=0 -> LEFT; deb_r=1 and deb_l=0 -> RIGHT; both high or both low -> stay IDLE.
REQ-017 LEFT or RIGHT: own lever debounced low -> IDLE; opposite lever debounced high -> IDLE; steer_ret rising edge (synchronized) -> LOCKOUT; on-counter = MAX_ON_CYCLES-1 -> LOCKOUT.
REQ-018 Priority in LEFT/RIGHT, highest first: own lever low, opposite lever high, steer_ret edge, timeout.
REQ-019 LOCKOUT: stay until deb_l=0 and deb_r=0, then -> IDLE.
REQ-020 The on-counter SHALL clear on every entry to LEFT or RIGHT, increment each cycle in those states, and saturate at MAX_ON_CYCLES-1; its width is clog2(MAX_ON_CYCLES).
REQ-021 Output registers: lt <= (state==LEFT) & ~haz_state; rt <= (state==RIGHT) & ~haz_state; haz <= haz_state.
REQ-022 lt and rt SHALL never be high in the same cycle; haz=1 SHALL force lt=rt=0.
REQ-023 The FSM SHALL keep running while haz_state=1, so clearing hazard restores any still-valid turn command.
REQ-024 Latency: a raw lever held stable from rising edge 0 SHALL drive lt/rt high after edge DEB_CYCLES+3; haz_btn toggles haz after the same latency.
REQ-025 A simultaneous hazard toggle and FSM transition SHALL both take effect in the same cycle.

Reset
REQ-026 While rst=1 at a rising edge: synchronizers, debounced values, debounce counters, on-counter and haz_state SHALL be 0; state SHALL be IDLE; lt, rt and haz SHALL be 0.
REQ-027 Reset mid-operation SHALL abort any turn or hazard; a lever held through reset SHALL re-qualify with the full REQ-024 latency after release of rst.

Structure
REQ-028 Shared package tail_light_pkg SHALL hold the turn_state_e enum and the DEB_CYCLES and MAX_ON_CYCLES default constants.
REQ-029 Sub-module sw_debounce, containing the synchronizer, debounce counter and debounced output, SHALL be instantiated once each for lever_l, lever_r and haz_btn.

Verification
REQ-030 DEB_CYCLES=4: hold lever_l high from edge 0 -> lt=1 after edge 7; rt=0 and haz=0 throughout.
REQ-031 Toggle lever_r every 2 cycles for 20 cycles, then hold low -> rt stays 0.
REQ-032 lever_l held, steer_ret pulsed for 3 cycles -> lt falls 4 edges after the pulse starts; lt stays 0 until lever_l is released and pressed again.
REQ-033 MAX_ON_CYCLES=16, lever_r held -> rt high for exactly 16 cycles, then 0 while the lever is still held.
REQ-034 lever_l held with lt=1, press and release haz_btn -> haz=1, lt=0; second press -> haz=0, lt=1 again.
REQ-035 Assert rst for 1 cycle while lt=1 and the lever is held -> all outputs 0 after the edge; lt returns after DEB_CYCLES+3 edges.
